call_register: RTL

- Request-side counterpart of the elevator status controller. The controller consumes up, down and car call vectors and reports floor and status. This block produces those vectors and retires each call once the controller reports the call as serviced.
- Latches button presses into pending hall-up, hall-down and car calls.
- Clears a call when the car opens its door at that floor in a compatible direction.
- Emits registered direction summaries (calls above, below, here) for the scheduler and LED display.

---
 rtl/call_register_pkg.sv | 29 ++
 rtl/call_register_call_bank.sv | 60 ++++++
 rtl/call_register.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/call_register_pkg.sv
// call_register_pkg: constants shared by the call register, the elevator
// status controller and the floor display.
//   - default floor count / floor index width
//   - bit positions inside the 4-bit controller status word
//   - helper that reduces the status word to a travel direction
package call_register_pkg;

    localparam int FLOORS_DEF = 8;
    localparam int FW_DEF     = 3;

    // Controller status word bit positions.
    localparam int ST_UP    = 3;
    localparam int ST_DOWN  = 2;
    localparam int ST_OPEN  = 1;
    localparam int ST_CLOSE = 0;

    // Encoded as {moving_down, moving_up}.
    typedef enum logic [1:0] {
        DIR_IDLE = 2'b00,
        DIR_UP   = 2'b01,
        DIR_DOWN = 2'b10,
        DIR_BOTH = 2'b11
    } dir_e;

    function automatic dir_e status_dir(input logic [3:0] st);
        return dir_e'({st[ST_DOWN], st[ST_UP]});
    endfunction

endpackage

// File: rtl/call_register_call_bank.sv
// call_bank: one FLOORS-bit bank of pending calls with its own press detector.
//   clk, rst      clock, asynchronous active-low reset
//   btn           debounced level buttons
//   clr           service-clear mask (highest priority)
//   cancel_en     a press on an already pending bit clears it
//   en_mask       bits allowed to exist; disabled bits stay 0
//   pend          registered pending calls
//   pend_next     next-state pending calls (post-update view)
//   rise          bits going 0->1 on the coming edge
module call_bank
    import call_register_pkg::*;
#(
    parameter int FLOORS = FLOORS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLOORS-1:0] btn,
    input  logic [FLOORS-1:0] clr,
    input  logic              cancel_en,
    input  logic [FLOORS-1:0] en_mask,
    output logic [FLOORS-1:0] pend,
    output logic [FLOORS-1:0] pend_next,
    output logic [FLOORS-1:0] rise
);

    logic [FLOORS-1:0] btn_q, btn_d;
    logic [FLOORS-1:0] pend_q, pend_d;
    logic              arm_q, arm_d;
    logic [FLOORS-1:0] press;
    logic [FLOORS-1:0] toggle;

    always_comb begin
        btn_d = btn;
        // arm_q is low for the first edge after reset so a button held
        // through reset only loads the history register.
        arm_d = 1'b1;
        press = btn & ~btn_q & {FLOORS{arm_q}} & en_mask;
        // Without cancel, a press on a pending bit is a no-op.
        toggle = cancel_en ? press : (press & ~pend_q);
        // Clear is applied last so it wins over both cancel and set.
        pend_d = (pend_q ^ toggle) & ~clr & en_mask;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_q  <= '0;
            pend_q <= '0;
            arm_q  <= 1'b0;
        end else begin
            btn_q  <= btn_d;
            pend_q <= pend_d;
            arm_q  <= arm_d;
        end
    end

    assign pend      = pend_q;
    assign pend_next = pend_d;
    assign rise      = pend_d & ~pend_q;

endmodule

// File: rtl/call_register.sv
// call_register: latches hall-up, hall-down and car button presses into
// pending call vectors for the status controller, retires them when the
// door opens at the floor, and publishes registered above/below/here
// summaries plus a new-call strobe.
//   clk, rst                     clock, asynchronous active-low reset
//   up_btn, down_btn, car_btn    debounced level buttons
//   floor, status                car position and status from the controller
//   up_call, down_call, car_call pending calls
//   any_above, any_below,
//   call_here                    registered summaries vs. floor
//   new_call                     one-cycle strobe on any new pending bit
module call_register
    import call_register_pkg::*;
#(
    parameter int FLOORS    = FLOORS_DEF,
    parameter int FW        = FW_DEF,
    parameter bit CANCEL_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLOORS-1:0] up_btn,
    input  logic [FLOORS-1:0] down_btn,
    input  logic [FLOORS-1:0] car_btn,
    input  logic [FW-1:0]     floor,
    input  logic [3:0]        status,
    output logic [FLOORS-1:0] up_call,
    output logic [FLOORS-1:0] down_call,
    output logic [FLOORS-1:0] car_call,
    output logic              any_above,
    output logic              any_below,
    output logic              call_here,
    output logic              new_call
);

    // No hall-up at the top floor, no hall-down at the bottom floor.
    localparam logic [FLOORS-1:0] UP_EN   = {1'b0, {(FLOORS-1){1'b1}}};
    localparam logic [FLOORS-1:0] DOWN_EN = {{(FLOORS-1){1'b1}}, 1'b0};
    localparam logic [FLOORS-1:0] ALL_EN  = '1;

    logic [FLOORS-1:0] up_clr, down_clr, car_clr;
    logic [FLOORS-1:0] up_n, down_n, car_n;
    logic [FLOORS-1:0] up_rise, down_rise, car_rise;
    logic [FLOORS-1:0] here_oh, any_n;
    dir_e              dir;
    logic              unused_close;

    logic any_above_q, any_above_d;
    logic any_below_q, any_below_d;
    logic call_here_q, call_here_d;
    logic new_call_q, new_call_d;

    assign unused_close = status[ST_CLOSE];

    // Service clear: level based, repeats every cycle the door is open.
    always_comb begin
        dir      = status_dir(status);
        here_oh  = '0;
        up_clr   = '0;
        down_clr = '0;
        car_clr  = '0;
        if (status[ST_OPEN] && (int'(floor) < FLOORS)) begin
            here_oh = FLOORS'(1) << floor;
            car_clr = here_oh;
            if (dir == DIR_IDLE || dir == DIR_UP) begin
                up_clr = here_oh;
            end
            if (dir == DIR_IDLE || dir == DIR_DOWN) begin
                down_clr = here_oh;
            end
        end
    end

    call_bank #(.FLOORS(FLOORS)) u_up (
        .clk       (clk),
        .rst       (rst),
        .btn       (up_btn),
        .clr       (up_clr),
        .cancel_en (1'b0),
        .en_mask   (UP_EN),
        .pend      (up_call),
        .pend_next (up_n),
        .rise      (up_rise)
    );

    call_bank #(.FLOORS(FLOORS)) u_down (
        .clk       (clk),
        .rst       (rst),
        .btn       (down_btn),
        .clr       (down_clr),
        .cancel_en (1'b0),
        .en_mask   (DOWN_EN),
        .pend      (down_call),
        .pend_next (down_n),
        .rise      (down_rise)
    );

    call_bank #(.FLOORS(FLOORS)) u_car (
        .clk       (clk),
        .rst       (rst),
        .btn       (car_btn),
        .clr       (car_clr),
        .cancel_en (CANCEL_EN),
        .en_mask   (ALL_EN),
        .pend      (car_call),
        .pend_next (car_n),
        .rise      (car_rise)
    );

    // Summaries use the post-update vectors so they line up with the
    // call outputs; a floor change shows up one cycle later.
    always_comb begin
        any_n       = up_n | down_n | car_n;
        any_above_d = 1'b0;
        any_below_d = 1'b0;
        call_here_d = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (i > int'(floor)) begin
                any_above_d = any_above_d | any_n[i];
            end else if (i < int'(floor)) begin
                any_below_d = any_below_d | any_n[i];
            end else begin
                call_here_d = call_here_d | any_n[i];
            end
        end
        new_call_d = |{up_rise, down_rise, car_rise};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            any_above_q <= 1'b0;
            any_below_q <= 1'b0;
            call_here_q <= 1'b0;
            new_call_q  <= 1'b0;
        end else begin
            any_above_q <= any_above_d;
            any_below_q <= any_below_d;
            call_here_q <= call_here_d;
            new_call_q  <= new_call_d;
        end
    end

    assign any_above = any_above_q;
    assign any_below = any_below_q;
    assign call_here = call_here_q;
    assign new_call  = new_call_q;

endmodule
